// File: rtl/imem_fetch_if.sv
// Instruction-fetch request/response channel between the IF stage (master)
// and the instruction memory responder (slave).
interface imem_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_addr;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, flush, resp_ready,
        input  req_ready, resp_valid, resp_addr, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, resp_ready,
        output req_ready, resp_valid, resp_addr, resp_inst, resp_err
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction RAM responder: fixed-latency read pipeline feeding a
// credit-limited response FIFO; responses return strictly in request order.
module imem_fetch_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_fetch_if.slave bus,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
);
    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      req_off;
    logic [31:0]      prog_off;
    logic             req_bad;
    logic             prog_ok;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] prog_idx;

    // Wrapping subtraction: addresses below BASE_ADDR land far above SPAN.
    assign req_off  = bus.req_addr - BASE_ADDR;
    assign prog_off = prog_addr - BASE_ADDR;
    assign req_bad  = (bus.req_addr < BASE_ADDR) || (req_off >= SPAN) ||
                      (bus.req_addr[1:0] != 2'b00);
    assign prog_ok  = (prog_addr >= BASE_ADDR) && (prog_off < SPAN) &&
                      (prog_addr[1:0] == 2'b00);
    assign req_idx  = req_off[IDX_W+1:2];
    assign prog_idx = prog_off[IDX_W+1:2];

    logic [CNT_W-1:0] count;
    logic             accept;
    logic             pop;
    logic             push;

    assign bus.req_ready = !bus.flush && (count < CNT_W'(FIFO_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.resp_valid && bus.resp_ready;

    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_err;
    logic [31:0]        pipe_addr [LATENCY];
    logic [31:0]        pipe_inst [LATENCY];

    assign push = pipe_valid[LATENCY-1];

    logic [31:0]     fifo_addr [FIFO_DEPTH];
    logic [31:0]     fifo_inst [FIFO_DEPTH];
    logic            fifo_err  [FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;
    logic            fifo_nonempty;

    assign fifo_nonempty = (wr_ptr != rd_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
        end else if (bus.flush) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // RAM and datapath storage carry no reset; only valid bits and pointers do.
    always_ff @(posedge clk) begin
        if (accept) begin
            pipe_addr[0] <= bus.req_addr;
            pipe_err[0]  <= req_bad;
            pipe_inst[0] <= req_bad ? NOP : mem[req_idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_err[i]  <= pipe_err[i-1];
            pipe_inst[i] <= pipe_inst[i-1];
        end
        if (prog_we && prog_ok) begin
            mem[prog_idx] <= prog_wdata;
        end
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= pipe_addr[LATENCY-1];
            fifo_inst[wr_ptr[PTR_W-1:0]] <= pipe_inst[LATENCY-1];
            fifo_err[wr_ptr[PTR_W-1:0]]  <= pipe_err[LATENCY-1];
        end
    end

    // Credits cover in-flight plus queued entries, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.resp_valid = fifo_nonempty;
    assign bus.resp_addr  = fifo_nonempty ? fifo_addr[rd_ptr[PTR_W-1:0]] : '0;
    assign bus.resp_inst  = fifo_nonempty ? fifo_inst[rd_ptr[PTR_W-1:0]] : '0;
    assign bus.resp_err   = fifo_nonempty ? fifo_err[rd_ptr[PTR_W-1:0]]  : 1'b0;

endmodule
